// File: rtl/display_pkg.sv
// display_pkg: shared constants, segment patterns and the display image record
// for the display_scan driver (optional blink via DISPLAY_SCAN_BLINK_EN).
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] DIG_OFF = 4'hF;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [7*NUM_DIGITS-1:0] seg;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } image_t;

    function automatic logic [NUM_DIGITS-1:0] dig_sel(input logic [1:0] i);
        logic [NUM_DIGITS-1:0] one_hot;
        one_hot = 4'b0001 << i;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/display_prescaler.sv
// display_prescaler: slot cycle counter and round-robin digit index; flags the
// blanking window, the frame boundary (last cycle of slot 3) and the frame start.
module display_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] slot_idx,
    output logic       blanking,
    output logic       frame_boundary,
    output logic       frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;
    logic          last;

    assign last           = cnt == CW'(REFRESH_DIV - 1);
    assign blanking       = cnt < CW'(BLANK_CYC);
    assign frame_boundary = last && slot_idx == 2'd3;
    assign frame_start    = cnt == '0 && slot_idx == 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            slot_idx <= 2'd0;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last)
                slot_idx <= slot_idx + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan.sv
// display_scan: double-buffered, time-multiplexed 4-digit 7-segment driver with
// blanking gaps; define DISPLAY_SCAN_BLINK_EN to add per-digit blinking.
module display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
`ifdef DISPLAY_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 125
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [27:0] upd_seg,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  upd_en,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic [3:0]  dig_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    logic [1:0] slot_idx;
    logic       blanking;
    logic       frame_boundary;
    logic       frame_start;

    display_prescaler #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_prescaler (
        .clk           (clk),
        .rst_n         (rst_n),
        .slot_idx      (slot_idx),
        .blanking      (blanking),
        .frame_boundary(frame_boundary),
        .frame_start   (frame_start)
    );

    image_t shadow;
    image_t active;
    logic   pending;

    assign upd_ready = !pending;

    // Capture and transfer are exclusive: ready is low whenever pending is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (upd_valid && upd_ready) begin
            shadow  <= '{seg: upd_seg, dp: upd_dp, en: upd_en};
            pending <= 1'b1;
        end else if (frame_boundary && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    logic [3:0] blink_mask;

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic [3:0]    blink_r;
    logic          frame_wrap;

    assign frame_wrap = frame_cnt == FW'(BLINK_FRAMES - 1);
    assign blink_mask = phase ? blink_r : 4'h0;

    // Blink requests and phase only change on frame boundaries, like image updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
            blink_r   <= 4'h0;
        end else if (frame_boundary) begin
            blink_r   <= blink;
            frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            if (frame_wrap)
                phase <= !phase;
        end
    end
`else
    assign blink_mask = 4'h0;
`endif

    logic [3:0] eff_en;
    logic [6:0] cur_seg;
    logic       lit;

    assign eff_en  = active.en & ~blink_mask;
    assign cur_seg = active.seg[7*int'(slot_idx) +: 7];
    assign lit     = !blanking && eff_en[slot_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_n      <= DIG_OFF;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            dig_n      <= lit ? dig_sel(slot_idx) : DIG_OFF;
            seg_n      <= lit ? ~cur_seg : SEG_OFF;
            dp_n       <= !(lit && active.dp[slot_idx]);
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: table-driven check of display_scan with an 8-cycle slot,
// 2-cycle blanking and 32-cycle frame, plus handshake and reset sequences.
module tb_display_scan;
    import display_pkg::*;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [27:0] upd_seg = '0;
    logic [3:0]  upd_dp = '0;
    logic [3:0]  upd_en = '0;
`ifdef DISPLAY_SCAN_BLINK_EN
    logic [3:0]  blink = '0;
`endif
    logic [3:0]  dig_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    always #5 clk = ~clk;

    display_scan #(
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC)
`ifdef DISPLAY_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_seg   (upd_seg),
        .upd_dp    (upd_dp),
        .upd_en    (upd_en),
`ifdef DISPLAY_SCAN_BLINK_EN
        .blink     (blink),
`endif
        .dig_n     (dig_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [27:0] seg;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  lit;
        logic [27:0] xseg;
        logic [3:0]  xdp;
    } vec_t;

    vec_t tbl[4];
    vec_t dark;
    int   total = 0;
    int   bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [12:0] expect_at(input vec_t v, input logic [3:0] lit, input int k);
        int         s;
        int         c;
        logic       on;
        logic [3:0] d;
        s  = k / RD;
        c  = k % RD;
        on = c >= BC && lit[s];
        d  = 4'b0001 << s;
        return {on ? ~d : 4'hF, on ? v.xseg[7*s +: 7] : 7'h7F, on ? v.xdp[s] : 1'b1, k == 0};
    endfunction

    task automatic check_frame(input vec_t v, input logic [3:0] lit, input string tag);
        for (int k = 0; k < 4 * RD; k++) begin
            check($sformatf("%s k=%0d {dig,seg,dp,tick}", tag, k),
                  {19'h0, dig_n, seg_n, dp_n, frame_tick}, {19'h0, expect_at(v, lit, k)});
            tick;
        end
    endtask

    task automatic load(input vec_t v);
        int n;
        upd_seg   = v.seg;
        upd_dp    = v.dp;
        upd_en    = v.en;
        upd_valid = 1'b1;
        n = 0;
        while (!upd_ready && n < 100) begin
            tick;
            n++;
        end
        tick;
        upd_valid = 1'b0;
        n = 0;
        while (!upd_ready && n < 100) begin
            tick;
            n++;
        end
        check("load ready timeout", {31'h0, upd_ready}, 32'h1);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        dark   = '0;
        tbl[0] = '{seg: {7'h00, 7'h00, 7'h00, 7'h3F}, dp: 4'b0000, en: 4'b0001, lit: 4'b0001,
                   xseg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, xdp: 4'b1111};
        tbl[1] = '{seg: {SEG_3, SEG_2, SEG_1, SEG_0}, dp: 4'b0100, en: 4'b1111, lit: 4'b1111,
                   xseg: {7'h30, 7'h24, 7'h79, 7'h40}, xdp: 4'b1011};
        tbl[2] = '{seg: {SEG_E, SEG_R, SEG_8, SEG_BLANK}, dp: 4'b1111, en: 4'b1010, lit: 4'b1010,
                   xseg: {7'h06, 7'h2F, 7'h00, 7'h7F}, xdp: 4'b0000};
        tbl[3] = '{seg: {SEG_8, SEG_8, SEG_8, SEG_8}, dp: 4'b1111, en: 4'b0000, lit: 4'b0000,
                   xseg: {7'h00, 7'h00, 7'h00, 7'h00}, xdp: 4'b0000};

        for (int i = 0; i < 3; i++) begin
            tick;
            check("reset outputs {dig,seg,dp,tick,ready}",
                  {18'h0, dig_n, seg_n, dp_n, frame_tick, upd_ready}, {18'h0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
        end
        rst_n = 1'b1;
        tick;
        check_frame(dark, 4'h0, "idle");

        for (int i = 0; i < 4; i++) begin
            load(tbl[i]);
            check_frame(tbl[i], tbl[i].lit, $sformatf("vec%0d", i));
        end

        load(tbl[1]);
        check_frame(tbl[1], 4'hF, "v1 first");
        for (int k = 0; k < 4 * RD; k++) begin
            check($sformatf("retain k=%0d {dig,seg,dp,tick}", k),
                  {19'h0, dig_n, seg_n, dp_n, frame_tick}, {19'h0, expect_at(tbl[1], 4'hF, k)});
            check($sformatf("ab ready k=%0d", k), {31'h0, upd_ready}, {31'h0, k <= 3 || k == 31});
            if (k == 3) begin
                upd_seg   = tbl[2].seg;
                upd_dp    = tbl[2].dp;
                upd_en    = tbl[2].en;
                upd_valid = 1'b1;
            end
            if (k == 4) begin
                upd_seg = tbl[0].seg;
                upd_dp  = tbl[0].dp;
                upd_en  = tbl[0].en;
            end
            tick;
        end
        check("B accepted after ready rise", {31'h0, upd_ready}, 32'h0);
        upd_valid = 1'b0;
        check_frame(tbl[2], tbl[2].lit, "A frame");
        check_frame(tbl[0], tbl[0].lit, "B frame");

        repeat (4) tick;
        check("pre-reset lit dig_n", {28'h0, dig_n}, {28'h0, 4'b1110});
        rst_n = 1'b0;
        #1;
        check("async reset {dig,seg,dp,tick,ready}",
              {18'h0, dig_n, seg_n, dp_n, frame_tick, upd_ready}, {18'h0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
        tick;
        rst_n = 1'b1;
        tick;
        check_frame(dark, 4'h0, "post-reset dark");

`ifdef DISPLAY_SCAN_BLINK_EN
        rst_n = 1'b0;
        blink = 4'b0001;
        tick;
        rst_n = 1'b1;
        load(tbl[1]);
        check_frame(tbl[1], 4'b1111, "blink f1");
        check_frame(tbl[1], 4'b1110, "blink f2");
        check_frame(tbl[1], 4'b1110, "blink f3");
        check_frame(tbl[1], 4'b1111, "blink f4");
        check_frame(tbl[1], 4'b1111, "blink f5");
        check_frame(tbl[1], 4'b1110, "blink f6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
